lfsr_stream_checker: RTL

//  Receive-side checker for the 64-bit CRC-style LFSR stimulus stream
//  (next = {s[62:0], s[63]^s[2]^s[0]}). The transmitter emits its feedback
//  bit once per valid cycle. This block self-synchronises to that stream,

---
 rtl/lfsr_stream_checker_if.sv | 21 ++
 rtl/lfsr_stream_checker.sv | 115 +++++++++++
 2 files changed

// File: rtl/lfsr_stream_checker_if.sv
// rtl/lfsr_stream_checker_if.sv - stream input and status bundle for the LFSR stream checker
interface lfsr_stream_checker_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_bit;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [1:0]       state;

    modport master (
        output in_valid, in_bit,
        input  locked, err_pulse, err_count, state
    );

    modport slave (
        input  in_valid, in_bit,
        output locked, err_pulse, err_count, state
    );
endinterface

// File: rtl/lfsr_stream_checker.sv
// rtl/lfsr_stream_checker.sv - self-synchronising per-bit checker for a 64-bit LFSR feedback stream
module lfsr_stream_checker #(
    parameter int WIDTH      = 64,
    parameter int CONFIRM_N  = 8,
    parameter int ERR_THRESH = 3,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    lfsr_stream_checker_if.slave bus
);
    localparam int FILL_W   = $clog2(WIDTH + 1);
    localparam int CONF_W   = $clog2(CONFIRM_N + 1);
    localparam int CONSEC_W = $clog2(ERR_THRESH + 1);

    localparam logic [FILL_W-1:0]   FILL_MAX    = FILL_W'(WIDTH);
    localparam logic [FILL_W-1:0]   FILL_LAST   = FILL_W'(WIDTH - 1);
    localparam logic [CONF_W-1:0]   CONF_LAST   = CONF_W'(CONFIRM_N - 1);
    localparam logic [CONSEC_W-1:0] CONSEC_LAST = CONSEC_W'(ERR_THRESH - 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t              st;
    logic [WIDTH-1:0]    shadow;
    logic [FILL_W-1:0]   fill;
    logic [CONF_W-1:0]   conf;
    logic [CONSEC_W-1:0] consec;
    logic                locked_q;
    logic                err_pulse_q;
    logic [CNT_W-1:0]    err_count_q;

    logic             pred;
    logic [WIDTH-1:0] rx_shift;

    assign pred     = shadow[WIDTH-1] ^ shadow[2] ^ shadow[0];
    assign rx_shift = {shadow[WIDTH-2:0], bus.in_bit};

    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= HUNT;
            shadow      <= '0;
            fill        <= '0;
            conf        <= '0;
            consec      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            if (bus.in_valid) begin
                case (st)
                    CONFIRM: begin
                        shadow <= rx_shift;
                        if (bus.in_bit == pred) begin
                            if (conf == CONF_LAST) begin
                                st       <= LOCKED;
                                locked_q <= 1'b1;
                                conf     <= '0;
                            end else begin
                                conf <= conf + 1'b1;
                            end
                        end else begin
                            st   <= HUNT;
                            fill <= '0;
                            conf <= '0;
                        end
                    end
                    // Flywheel: track our own prediction so isolated bad bits don't desync us.
                    LOCKED: begin
                        shadow <= {shadow[WIDTH-2:0], pred};
                        if (bus.in_bit != pred) begin
                            err_pulse_q <= 1'b1;
                            if (err_count_q != '1) begin
                                err_count_q <= err_count_q + 1'b1;
                            end
                            if (consec == CONSEC_LAST) begin
                                st       <= HUNT;
                                locked_q <= 1'b0;
                                fill     <= '0;
                                conf     <= '0;
                                consec   <= '0;
                            end else begin
                                consec <= consec + 1'b1;
                            end
                        end else begin
                            consec <= '0;
                        end
                    end
                    // HUNT, and the unused encoding which behaves as HUNT.
                    default: begin
                        shadow <= rx_shift;
                        if (fill != FILL_MAX) begin
                            fill <= fill + 1'b1;
                        end
                        if ((fill == FILL_MAX || fill == FILL_LAST) && rx_shift != '0) begin
                            st   <= CONFIRM;
                            conf <= '0;
                        end else begin
                            st <= HUNT;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;
    assign bus.state     = st;
endmodule
